// File: rtl/coreuart_apb_regif.sv
// APB3 slave register front-end for CoreUART: turns APB transfers into single-cycle
// active-low core strobes, holds baud/format configuration and raises a maskable interrupt.
module coreuart_apb_regif #(
    parameter int APB_DWIDTH        = 32,
    parameter int FIXEDMODE         = 0,
    parameter int BAUD_VALUE        = 1,
    parameter int PRG_BIT8          = 1,
    parameter int PRG_PARITY        = 0,
    parameter int BAUD_VAL_FRCTN_EN = 0
) (
    input  logic                  CLK,
    input  logic                  aresetn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [4:0]            PADDR,
    input  logic [APB_DWIDTH-1:0] PWDATA,
    output logic [APB_DWIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic                  INTR,
    output logic                  CSN,
    output logic                  WEN,
    output logic                  OEN,
    output logic [7:0]            DATA_IN,
    output logic [12:0]           BAUD_VAL,
    output logic [2:0]            BAUD_VAL_FRACTION,
    output logic                  BIT8,
    output logic                  PARITY_EN,
    output logic                  ODD_N_EVEN,
    input  logic [7:0]            DATA_OUT,
    input  logic                  TXRDY,
    input  logic                  RXRDY,
    input  logic                  PARITY_ERR,
    input  logic                  OVERFLOW,
    input  logic                  FRAMING_ERR
);

    localparam logic [4:0] ADDR_TXDATA = 5'h00;
    localparam logic [4:0] ADDR_RXDATA = 5'h04;
    localparam logic [4:0] ADDR_CTRL1  = 5'h08;
    localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
    localparam logic [4:0] ADDR_STATUS = 5'h10;
    localparam logic [4:0] ADDR_CTRL3  = 5'h14;
    localparam logic [4:0] ADDR_IEN    = 5'h18;

    localparam logic        FIXED     = (FIXEDMODE != 0);
    localparam logic        FRAC_WR   = !FIXED && (BAUD_VAL_FRCTN_EN != 0);
    localparam logic [12:0] FIX_BAUD  = 13'(BAUD_VALUE);
    localparam logic [7:0]  FIX_CTRL2 = {FIX_BAUD[12:8], (PRG_PARITY == 2),
                                         (PRG_PARITY != 0), (PRG_BIT8 != 0)};

    typedef enum logic [1:0] {IDLE, ACC1, ACC2} state_t;

    state_t      state_q, state_d;
    logic [4:0]  addr_q, addr_d;
    logic        write_q, write_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  prdata_q, prdata_d;
    logic        pready_q, pready_d;
    logic        pslverr_q, pslverr_d;
    logic        intr_q, intr_d;
    logic        csn_q, csn_d, wen_q, wen_d, oen_q, oen_d;
    logic [7:0]  data_in_q, data_in_d;
    logic [7:0]  ctrl1_q, ctrl1_d, ctrl2_q, ctrl2_d;
    logic [2:0]  frac_q, frac_d, ien_q, ien_d;

    logic [7:0]  ctrl1_eff, ctrl2_eff, rd_byte;
    logic [2:0]  frac_eff;
    logic        unused_pwdata;

    assign ctrl1_eff     = FIXED ? FIX_BAUD[7:0] : ctrl1_q;
    assign ctrl2_eff     = FIXED ? FIX_CTRL2 : ctrl2_q;
    assign frac_eff      = FRAC_WR ? frac_q : 3'd0;
    assign unused_pwdata = ^PWDATA;

    // Read data for zero-wait registers is taken from the setup-phase address.
    always_comb begin
        rd_byte = 8'h00;
        case (PADDR)
            ADDR_STATUS: rd_byte = {3'b000, FRAMING_ERR, OVERFLOW, PARITY_ERR, RXRDY, TXRDY};
            ADDR_CTRL1:  rd_byte = ctrl1_eff;
            ADDR_CTRL2:  rd_byte = ctrl2_eff;
            ADDR_CTRL3:  rd_byte = {5'b00000, frac_eff};
            ADDR_IEN:    rd_byte = {5'b00000, ien_q};
            default:     rd_byte = 8'h00;
        endcase
    end

    always_comb begin
        // NOTE: every _d gets a default before the case so no path can infer a latch.
        state_d   = state_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        prdata_d  = prdata_q;
        pready_d  = 1'b1;
        pslverr_d = 1'b0;
        csn_d     = 1'b1;
        wen_d     = 1'b1;
        oen_d     = 1'b1;
        data_in_d = data_in_q;
        ctrl1_d   = ctrl1_q;
        ctrl2_d   = ctrl2_q;
        frac_d    = frac_q;
        ien_d     = ien_q;
        intr_d    = (TXRDY & ien_q[0]) | (RXRDY & ien_q[1])
                  | ((PARITY_ERR | OVERFLOW | FRAMING_ERR) & ien_q[2]);

        unique case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d  = ACC1;
                    addr_d   = PADDR;
                    write_d  = PWRITE;
                    wdata_d  = PWDATA[7:0];
                    prdata_d = PWRITE ? 8'h00 : rd_byte;
                    if (PWRITE && PADDR == ADDR_TXDATA) begin
                        if (TXRDY) begin
                            csn_d     = 1'b0;
                            wen_d     = 1'b0;
                            data_in_d = PWDATA[7:0];
                        end else begin
                            pslverr_d = 1'b1;
                        end
                    end else if (!PWRITE && PADDR == ADDR_RXDATA) begin
                        // Strobe even when RXRDY=0: the read clears the core's sticky errors.
                        csn_d     = 1'b0;
                        oen_d     = 1'b0;
                        pready_d  = 1'b0;
                        pslverr_d = !RXRDY;
                    end
                end
            end
            ACC1: begin
                state_d = IDLE;
                if (PSEL && !write_q && addr_q == ADDR_RXDATA) begin
                    state_d   = ACC2;
                    prdata_d  = DATA_OUT;
                    pslverr_d = pslverr_q;
                end else if (PSEL && write_q) begin
                    case (addr_q)
                        ADDR_CTRL1: if (!FIXED) ctrl1_d = wdata_q;
                        ADDR_CTRL2: if (!FIXED) ctrl2_d = wdata_q;
                        ADDR_CTRL3: if (FRAC_WR) frac_d = wdata_q[2:0];
                        ADDR_IEN:   ien_d = wdata_q[2:0];
                        default:    ;
                    endcase
                end
            end
            ACC2:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            addr_q    <= 5'h00;
            write_q   <= 1'b0;
            wdata_q   <= 8'h00;
            prdata_q  <= 8'h00;
            pready_q  <= 1'b1;
            pslverr_q <= 1'b0;
            intr_q    <= 1'b0;
            csn_q     <= 1'b1;
            wen_q     <= 1'b1;
            oen_q     <= 1'b1;
            data_in_q <= 8'h00;
            ctrl1_q   <= 8'h01;
            ctrl2_q   <= 8'h01;
            frac_q    <= 3'd0;
            ien_q     <= 3'd0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            intr_q    <= intr_d;
            csn_q     <= csn_d;
            wen_q     <= wen_d;
            oen_q     <= oen_d;
            data_in_q <= data_in_d;
            ctrl1_q   <= ctrl1_d;
            ctrl2_q   <= ctrl2_d;
            frac_q    <= frac_d;
            ien_q     <= ien_d;
        end
    end

    assign PRDATA            = APB_DWIDTH'(prdata_q);
    assign PREADY            = pready_q;
    assign PSLVERR           = pslverr_q;
    assign INTR              = intr_q;
    assign CSN               = csn_q;
    assign WEN               = wen_q;
    assign OEN               = oen_q;
    assign DATA_IN           = data_in_q;
    assign BAUD_VAL          = {ctrl2_eff[7:3], ctrl1_eff};
    assign BAUD_VAL_FRACTION = frac_eff;
    assign ODD_N_EVEN        = ctrl2_eff[2];
    assign PARITY_EN         = ctrl2_eff[1];
    assign BIT8              = ctrl2_eff[0];

endmodule

// File: tb/tb_coreuart_apb_regif.sv
// Self-checking bench for coreuart_apb_regif: directed vector table, hand-written corner
// sequences, then randomized APB traffic against a register-level reference model.
module tb_coreuart_apb_regif;

    logic        CLK = 1'b0;
    logic        aresetn;
    logic        PSEL, PENABLE, PWRITE;
    logic [4:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR, INTR, CSN, WEN, OEN;
    logic [7:0]  DATA_IN, DATA_OUT;
    logic [12:0] BAUD_VAL;
    logic [2:0]  BAUD_VAL_FRACTION;
    logic        BIT8, PARITY_EN, ODD_N_EVEN;
    logic        TXRDY, RXRDY, PARITY_ERR, OVERFLOW, FRAMING_ERR;

    coreuart_apb_regif dut (
        .CLK(CLK), .aresetn(aresetn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .INTR(INTR), .CSN(CSN), .WEN(WEN), .OEN(OEN), .DATA_IN(DATA_IN), .BAUD_VAL(BAUD_VAL),
        .BAUD_VAL_FRACTION(BAUD_VAL_FRACTION), .BIT8(BIT8), .PARITY_EN(PARITY_EN),
        .ODD_N_EVEN(ODD_N_EVEN), .DATA_OUT(DATA_OUT), .TXRDY(TXRDY), .RXRDY(RXRDY),
        .PARITY_ERR(PARITY_ERR), .OVERFLOW(OVERFLOW), .FRAMING_ERR(FRAMING_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       wr;
        logic [4:0] addr;
        logic [7:0] wd;
        logic       tx, rx;
        logic [2:0] st;      // {FRAMING_ERR, OVERFLOW, PARITY_ERR}
        logic [7:0] dout;
        logic [7:0] exp_rd;
        logic       exp_err;
        int         exp_waits, exp_csn, exp_wen, exp_oen;
        logic [7:0] exp_din;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t        tbl[20];
    logic [31:0] rd;
    logic        err, tmo;
    int          waits, n_csn, n_wen, n_oen;

    // Reference model state: register contents as seen by software.
    logic [7:0]  m_ctrl1, m_ctrl2, m_din;
    logic [2:0]  m_ien;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(logic wr, logic [4:0] a, logic [7:0] wd, logic tx, logic rx,
                               logic [2:0] st, logic [7:0] dout, logic [7:0] erd, logic eerr,
                               int ew, int ec, int ewn, int eo, logic [7:0] edin);
        vec_t r;
        r.wr = wr; r.addr = a; r.wd = wd; r.tx = tx; r.rx = rx; r.st = st; r.dout = dout;
        r.exp_rd = erd; r.exp_err = eerr; r.exp_waits = ew; r.exp_csn = ec;
        r.exp_wen = ewn; r.exp_oen = eo; r.exp_din = edin;
        return r;
    endfunction

    task automatic drive_core(input logic tx, input logic rx, input logic [2:0] st,
                              input logic [7:0] dout);
        TXRDY = tx;
        RXRDY = rx;
        {FRAMING_ERR, OVERFLOW, PARITY_ERR} = st;
        DATA_OUT = dout;
    endtask

    // One complete APB transfer starting just after a rising edge; counts strobe-low cycles.
    task automatic apb_xfer(input logic wr, input logic [4:0] a, input logic [7:0] wd,
                            output logic [31:0] rdata, output logic e, output int w,
                            output int c, output int wn, output int o, output logic to);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a;
        PWDATA = {24'($urandom), wd};
        w = 0; c = 0; wn = 0; o = 0; to = 1'b0;
        @(posedge CLK); #1;
        PENABLE = 1'b1;
        forever begin
            c += int'(!CSN); wn += int'(!WEN); o += int'(!OEN);
            if (PREADY) break;
            w++;
            if (w > 8) begin to = 1'b1; break; end
            @(posedge CLK); #1;
        end
        rdata = PRDATA; e = PSLVERR;
        @(posedge CLK); #1;
        c += int'(!CSN); wn += int'(!WEN); o += int'(!OEN);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    function automatic logic [7:0] m_read(logic [4:0] a, logic tx, logic rx, logic [2:0] st,
                                          logic [7:0] dout);
        case (a)
            5'h04:   return dout;
            5'h08:   return m_ctrl1;
            5'h0C:   return m_ctrl2;
            5'h10:   return {3'b000, st, rx, tx};
            5'h18:   return {5'b00000, m_ien};
            default: return 8'h00;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        aresetn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        drive_core(1'b1, 1'b0, 3'b000, 8'h00);

        tbl[0]  = v(0, 5'h08, 8'h00, 1, 0, 3'b000, 8'h00, 8'h01, 0, 0, 0, 0, 0, 8'h00);
        tbl[1]  = v(0, 5'h0C, 8'h00, 1, 0, 3'b000, 8'h00, 8'h01, 0, 0, 0, 0, 0, 8'h00);
        tbl[2]  = v(1, 5'h00, 8'hA5, 1, 0, 3'b000, 8'h00, 8'h00, 0, 0, 1, 1, 0, 8'hA5);
        tbl[3]  = v(1, 5'h00, 8'h5A, 0, 0, 3'b000, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'hA5);
        tbl[4]  = v(0, 5'h04, 8'h00, 1, 1, 3'b000, 8'h3C, 8'h3C, 0, 1, 1, 0, 1, 8'hA5);
        tbl[5]  = v(0, 5'h04, 8'h00, 1, 0, 3'b000, 8'h77, 8'h77, 1, 1, 1, 0, 1, 8'hA5);
        tbl[6]  = v(1, 5'h0C, 8'hFB, 1, 0, 3'b000, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'hA5);
        tbl[7]  = v(1, 5'h08, 8'h12, 1, 0, 3'b000, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'hA5);
        tbl[8]  = v(0, 5'h0C, 8'h00, 1, 0, 3'b000, 8'h00, 8'hFB, 0, 0, 0, 0, 0, 8'hA5);
        tbl[9]  = v(0, 5'h08, 8'h00, 1, 0, 3'b000, 8'h00, 8'h12, 0, 0, 0, 0, 0, 8'hA5);
        tbl[10] = v(0, 5'h10, 8'h00, 1, 0, 3'b000, 8'h00, 8'h01, 0, 0, 0, 0, 0, 8'hA5);
        tbl[11] = v(0, 5'h10, 8'h00, 0, 1, 3'b101, 8'h00, 8'h16, 0, 0, 0, 0, 0, 8'hA5);
        tbl[12] = v(1, 5'h1C, 8'hFF, 1, 0, 3'b000, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'hA5);
        tbl[13] = v(0, 5'h1C, 8'h00, 1, 0, 3'b000, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'hA5);
        tbl[14] = v(1, 5'h14, 8'h07, 1, 0, 3'b000, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'hA5);
        tbl[15] = v(0, 5'h14, 8'h00, 1, 0, 3'b000, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'hA5);
        tbl[16] = v(0, 5'h00, 8'h00, 1, 0, 3'b000, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'hA5);
        tbl[17] = v(1, 5'h10, 8'hFF, 1, 0, 3'b000, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'hA5);
        tbl[18] = v(0, 5'h18, 8'h00, 1, 0, 3'b000, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'hA5);
        tbl[19] = v(1, 5'h04, 8'h55, 1, 1, 3'b000, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'hA5);

        repeat (3) @(posedge CLK);
        @(negedge CLK); aresetn = 1'b1;
        @(posedge CLK); #1;
        check("rst PREADY", 32'(PREADY), 32'd1);
        check("rst strobes", {29'd0, CSN, WEN, OEN}, 32'd7);
        check("rst BAUD_VAL", 32'(BAUD_VAL), 32'd1);
        check("rst BIT8/PAR/ODD", {29'd0, BIT8, PARITY_EN, ODD_N_EVEN}, 32'd4);
        check("rst INTR/PSLVERR", {30'd0, INTR, PSLVERR}, 32'd0);
        check("rst PRDATA", PRDATA, 32'd0);
        check("rst DATA_IN", 32'(DATA_IN), 32'd0);

        foreach (tbl[i]) begin
            drive_core(tbl[i].tx, tbl[i].rx, tbl[i].st, tbl[i].dout);
            apb_xfer(tbl[i].wr, tbl[i].addr, tbl[i].wd, rd, err, waits, n_csn, n_wen, n_oen, tmo);
            check($sformatf("vec%0d timeout", i), 32'(tmo), 32'd0);
            if (!tbl[i].wr) check($sformatf("vec%0d PRDATA", i), rd, 32'(tbl[i].exp_rd));
            check($sformatf("vec%0d PSLVERR", i), 32'(err), 32'(tbl[i].exp_err));
            check($sformatf("vec%0d waits", i), 32'(waits), 32'(tbl[i].exp_waits));
            check($sformatf("vec%0d strobes c/w/o", i), {8'd0, 8'(n_csn), 8'(n_wen), 8'(n_oen)},
                  {8'd0, 8'(tbl[i].exp_csn), 8'(tbl[i].exp_wen), 8'(tbl[i].exp_oen)});
            check($sformatf("vec%0d DATA_IN", i), 32'(DATA_IN), 32'(tbl[i].exp_din));
        end
        check("cfg BAUD_VAL", 32'(BAUD_VAL), 32'h1F12);
        check("cfg BIT8/PAR/ODD", {29'd0, BIT8, PARITY_EN, ODD_N_EVEN}, 32'd6);
        check("cfg FRACTION", 32'(BAUD_VAL_FRACTION), 32'd0);

        // Interrupt lags its sources by exactly one clock.
        drive_core(1'b0, 1'b0, 3'b000, 8'h00);
        apb_xfer(1'b1, 5'h18, 8'h02, rd, err, waits, n_csn, n_wen, n_oen, tmo);
        @(posedge CLK); #1;
        check("intr idle", 32'(INTR), 32'd0);
        RXRDY = 1'b1;
        #1 check("intr no comb path", 32'(INTR), 32'd0);
        @(posedge CLK); #1;
        check("intr set", 32'(INTR), 32'd1);
        RXRDY = 1'b0;
        @(posedge CLK); #1;
        check("intr clear", 32'(INTR), 32'd0);

        // Aborted RX read: strobes release on the next edge, bus returns to idle.
        drive_core(1'b1, 1'b1, 3'b000, 8'h99);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 5'h04;
        @(posedge CLK); #1;
        check("abort OEN low", {30'd0, OEN, PREADY}, 32'd0);
        PSEL = 1'b0;
        @(posedge CLK); #1;
        check("abort strobes high", {29'd0, CSN, OEN, PREADY}, 32'd7);
        // Aborted CTRL1 write must not change the register.
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 5'h08; PWDATA = 32'h55;
        @(posedge CLK); #1;
        PSEL = 1'b0;
        @(posedge CLK); #1;
        apb_xfer(1'b0, 5'h08, 8'h00, rd, err, waits, n_csn, n_wen, n_oen, tmo);
        check("abort keeps CTRL1", rd, 32'h12);

        m_ctrl1 = 8'h12; m_ctrl2 = 8'hFB; m_ien = 3'd2; m_din = 8'hA5;
        for (int k = 0; k < 150; k++) begin
            logic       wr, tx, rx, exp_err;
            logic [4:0] a;
            logic [7:0] wd, dout;
            logic [2:0] st;
            int         sel;
            wr   = 1'($urandom_range(0, 1));
            tx   = 1'($urandom_range(0, 1));
            rx   = 1'($urandom_range(0, 1));
            st   = 3'($urandom_range(0, 7));
            wd   = 8'($urandom);
            dout = 8'($urandom);
            sel  = $urandom_range(0, 9);
            a    = (sel < 8) ? 5'(sel * 4) : ((sel == 8) ? 5'($urandom) : 5'h18);
            drive_core(tx, rx, st, dout);
            apb_xfer(wr, a, wd, rd, err, waits, n_csn, n_wen, n_oen, tmo);
            check($sformatf("rnd%0d timeout", k), 32'(tmo), 32'd0);
            if (!wr) check($sformatf("rnd%0d PRDATA a=%0h", k, a), rd, 32'(m_read(a, tx, rx, st, dout)));
            exp_err = (wr && a == 5'h00 && !tx) || (!wr && a == 5'h04 && !rx);
            check($sformatf("rnd%0d PSLVERR", k), 32'(err), 32'(exp_err));
            check($sformatf("rnd%0d waits", k), 32'(waits), 32'(!wr && a == 5'h04));
            check($sformatf("rnd%0d strobes", k), {8'd0, 8'(n_csn), 8'(n_wen), 8'(n_oen)},
                  {8'd0, 8'((wr && a == 5'h00 && tx) || (!wr && a == 5'h04)),
                   8'(wr && a == 5'h00 && tx), 8'(!wr && a == 5'h04)});
            if (wr) begin
                if (a == 5'h08) m_ctrl1 = wd;
                if (a == 5'h0C) m_ctrl2 = wd;
                if (a == 5'h18) m_ien = wd[2:0];
                if (a == 5'h00 && tx) m_din = wd;
            end
            @(posedge CLK); #1;
            check($sformatf("rnd%0d DATA_IN", k), 32'(DATA_IN), 32'(m_din));
            check($sformatf("rnd%0d BAUD_VAL", k), 32'(BAUD_VAL), 32'({m_ctrl2[7:3], m_ctrl1}));
            check($sformatf("rnd%0d format", k), {29'd0, ODD_N_EVEN, PARITY_EN, BIT8},
                  32'(m_ctrl2[2:0]));
            check($sformatf("rnd%0d INTR", k), 32'(INTR),
                  32'((tx & m_ien[0]) | (rx & m_ien[1]) | ((|st) & m_ien[2])));
        end

        // Reset in the middle of a TX write: strobes release immediately, config restored.
        drive_core(1'b1, 1'b0, 3'b000, 8'h00);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 5'h00; PWDATA = 32'hC3;
        @(posedge CLK); #1;
        check("midrst strobe low", {30'd0, CSN, WEN}, 32'd0);
        aresetn = 1'b0;
        #1;
        check("midrst strobes", {29'd0, CSN, WEN, OEN}, 32'd7);
        check("midrst PREADY/PSLVERR", {30'd0, PREADY, PSLVERR}, 32'd2);
        check("midrst DATA_IN", 32'(DATA_IN), 32'd0);
        check("midrst BAUD_VAL", 32'(BAUD_VAL), 32'd1);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge CLK); aresetn = 1'b1;
        @(posedge CLK); #1;
        apb_xfer(1'b0, 5'h08, 8'h00, rd, err, waits, n_csn, n_wen, n_oen, tmo);
        check("postrst CTRL1", rd, 32'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
